// File: rtl/conv_window_gen.sv
// Sliding K_H x K_W window generator over a raster pixel stream.
// Line buffers keep the previous K_H-1 rows; a shift window assembles each output window.
module conv_window_gen #(
   parameter int IMG_W = 16,
   parameter int IMG_H = 16,
   parameter int K_H   = 3,
   parameter int K_W   = 3
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               pix_valid,
   output logic                               pix_ready,
   input  logic [7:0]                         pix_data,
   output logic                               win_valid,
   input  logic                               win_ready,
   output logic [K_H-1:0][K_W-1:0][7:0]       win,
   output logic [$clog2(IMG_H)-1:0]           win_row,
   output logic [$clog2(IMG_W)-1:0]           win_col,
   output logic                               win_last
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);

   typedef enum logic {FILL, STREAM} phase_t;

   phase_t phase, phase_nxt;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [7:0] lb [K_H-1][IMG_W];
   logic [K_H-1:0][K_W-1:0][7:0] shift_win, shift_nxt;
   logic [K_H-1:0][7:0] new_col;
   logic accept, emit, col_end, frame_end, fill_done;

   assign pix_ready = !win_valid || win_ready;
   assign accept    = pix_valid && pix_ready && !rst;
   assign col_end   = (col == CW'(IMG_W - 1));
   assign frame_end = col_end && (row == RW'(IMG_H - 1));
   assign fill_done = col_end && (row == RW'(K_H - 2));

   always_ff @(posedge clk) begin
      if (rst) begin
         col <= '0;
         row <= '0;
      end else if (accept) begin
         if (col_end) begin
            col <= '0;
            row <= (row == RW'(IMG_H - 1)) ? '0 : row + RW'(1);
         end else begin
            col <= col + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) phase <= FILL;
      else     phase <= phase_nxt;
   end

   always_comb begin
      phase_nxt = phase;
      case (phase)
         FILL:    if (accept && fill_done) phase_nxt = STREAM;
         STREAM:  if (accept && frame_end) phase_nxt = FILL;
         default: phase_nxt = FILL;
      endcase
   end

   always_comb begin
      emit = 1'b0;
      if (accept && phase == STREAM && col >= CW'(K_W - 1)) emit = 1'b1;
   end

   // Column entering the window: oldest buffered row on top, incoming pixel at the bottom.
   always_comb begin
      for (int k = 0; k < K_H - 1; k++) new_col[k] = lb[K_H-2-k][col];
      new_col[K_H-1] = pix_data;
   end

   always_comb begin
      for (int r = 0; r < K_H; r++) begin
         for (int c = 0; c < K_W - 1; c++) shift_nxt[r][c] = shift_win[r][c+1];
         shift_nxt[r][K_W-1] = new_col[r];
      end
   end

   // Datapath storage is never reset; the phase and column gating keeps stale data out.
   always_ff @(posedge clk) begin
      if (accept) begin
         shift_win <= shift_nxt;
         for (int i = 1; i < K_H - 1; i++) lb[i][col] <= lb[i-1][col];
         lb[0][col] <= pix_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         win_valid <= 1'b0;
         win       <= '0;
         win_row   <= '0;
         win_col   <= '0;
         win_last  <= 1'b0;
      end else if (accept) begin
         win_valid <= emit;
         if (emit) begin
            win      <= shift_nxt;
            win_row  <= row - RW'(K_H - 1);
            win_col  <= col - CW'(K_W - 1);
            win_last <= frame_end;
         end
      end else if (win_ready) begin
         win_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen: three configurations share one stimulus/monitor flow.
// Expected windows are cut straight out of a stored frame and queued before the frame is sent.
module tb_conv_window_gen;

   typedef struct {
      int               sel;
      int               row;
      int               col;
      logic             last;
      logic [8:0][7:0]  px;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic [2:0] pv, pr, wr, wv, wl;
   logic [2:0][7:0] pd;
   logic [2:0][8:0][7:0] fw;
   logic [2:0][3:0] wrow, wcol;

   logic [2:0][2:0][7:0] win_a, win_b;
   logic [2:0][1:0][7:0] win_c;
   logic [1:0] row_a, col_a, row_c;
   logic [3:0] row_b, col_b;
   logic [2:0] col_c;

   exp_t sb[$];
   logic [7:0] frame [256];
   int checks = 0;
   int errors = 0;
   int recv = 0;
   int rmode = 0;
   bit stalled = 0;
   logic [95:0] snap;

   conv_window_gen #(.IMG_W(4), .IMG_H(4), .K_H(3), .K_W(3)) dut_a (
      .clk(clk), .rst(rst), .pix_valid(pv[0]), .pix_ready(pr[0]), .pix_data(pd[0]),
      .win_valid(wv[0]), .win_ready(wr[0]), .win(win_a), .win_row(row_a),
      .win_col(col_a), .win_last(wl[0]));

   conv_window_gen #(.IMG_W(16), .IMG_H(16), .K_H(3), .K_W(3)) dut_b (
      .clk(clk), .rst(rst), .pix_valid(pv[1]), .pix_ready(pr[1]), .pix_data(pd[1]),
      .win_valid(wv[1]), .win_ready(wr[1]), .win(win_b), .win_row(row_b),
      .win_col(col_b), .win_last(wl[1]));

   conv_window_gen #(.IMG_W(5), .IMG_H(3), .K_H(3), .K_W(2)) dut_c (
      .clk(clk), .rst(rst), .pix_valid(pv[2]), .pix_ready(pr[2]), .pix_data(pd[2]),
      .win_valid(wv[2]), .win_ready(wr[2]), .win(win_c), .win_row(row_c),
      .win_col(col_c), .win_last(wl[2]));

   // Flatten every instance's window into a common row-major 9-byte view.
   for (genvar i = 0; i < 3; i++) begin : g_row
      for (genvar j = 0; j < 3; j++) begin : g_col3
         assign fw[0][i*3+j] = win_a[i][j];
         assign fw[1][i*3+j] = win_b[i][j];
      end
      for (genvar j = 0; j < 2; j++) begin : g_col2
         assign fw[2][i*2+j] = win_c[i][j];
      end
   end
   assign fw[2][8:6] = '0;

   assign wrow[0] = {2'b00, row_a};
   assign wrow[1] = row_b;
   assign wrow[2] = {2'b00, row_c};
   assign wcol[0] = {2'b00, col_a};
   assign wcol[1] = col_b;
   assign wcol[2] = {1'b0, col_c};

   task automatic check_output(input string name, input logic [95:0] got, input logic [95:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   // Reference: every valid window position of the stored frame, in raster order.
   task automatic push_windows(input int sel, input int w, input int h, input int kh, input int kw);
      exp_t e;
      for (int r = kh - 1; r < h; r++) begin
         for (int c = kw - 1; c < w; c++) begin
            e.sel  = sel;
            e.row  = r - kh + 1;
            e.col  = c - kw + 1;
            e.last = (r == h - 1 && c == w - 1);
            e.px   = '0;
            for (int i = 0; i < kh; i++)
               for (int j = 0; j < kw; j++)
                  e.px[i*kw+j] = frame[(e.row + i) * w + e.col + j];
            sb.push_back(e);
         end
      end
   endtask

   task automatic apply_stimulus(input int sel, input int w, input int h, input int kh, input int kw,
                                 input int base, input bit rnd, input int n_pix, input int gap_pct,
                                 input bit lat);
      int first_idx;
      bit acc;
      first_idx = (kh - 1) * w + kw - 1;
      for (int i = 0; i < w * h; i++) frame[i] = rnd ? 8'($urandom) : 8'(base + i);
      if (n_pix == w * h) push_windows(sel, w, h, kh, kw);
      for (int i = 0; i < n_pix; i++) begin
         if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            pv[sel] = 1'b0;
            @(posedge clk); #1;
         end
         pv[sel] = 1'b1;
         pd[sel] = frame[i];
         acc = 1'b0;
         for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            acc = pr[sel];
            if (acc && lat && i <= first_idx) check_output("valid_before_first", 96'(wv[sel]), 96'(0));
            @(posedge clk); #1;
         end
         if (!acc) begin
            checks++;
            errors++;
            $display("[TB] FAIL pix_accept_timeout sel=%0d idx=%0d got=stalled want=accepted", sel, i);
            pv[sel] = 1'b0;
            return;
         end
         if (lat && i == first_idx) check_output("first_valid_latency", 96'(wv[sel]), 96'(1));
      end
      pv[sel] = 1'b0;
   endtask

   task automatic drain(input int sel, input int n_exp, input int recv0);
      for (int t = 0; t < 2000 && sb.size() != 0; t++) begin
         @(posedge clk); #1;
      end
      check_output("drain_queue_empty", 96'(sb.size()), 96'(0));
      check_output("window_count", 96'(recv - recv0), 96'(n_exp));
      @(posedge clk); #1;
      check_output("valid_low_after_drain", 96'(wv[sel]), 96'(0));
   endtask

   // Monitor: every output handshake retires the oldest expected window.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         for (int s = 0; s < 3; s++) begin
            if (wv[s] && wr[s]) begin
               recv++;
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL unexpected_window sel=%0d got row=%0d col=%0d want=none",
                           s, wrow[s], wcol[s]);
               end else begin
                  e = sb.pop_front();
                  check_output("window",
                     96'({2'(s), wrow[s], wcol[s], wl[s], fw[s]}),
                     96'({2'(e.sel), 4'(e.row), 4'(e.col), e.last, e.px}));
               end
            end
         end
      end
   end

   // Consumer: always ready, random ready, or a single 5-cycle stall on the first window of dut_a.
   initial begin
      wr = '1;
      forever begin
         @(posedge clk); #1;
         if (rmode == 1) begin
            wr = 3'($urandom);
         end else if (rmode == 2 && !stalled && wv[0]) begin
            stalled = 1'b1;
            snap = 96'({wrow[0], wcol[0], wl[0], fw[0]});
            wr = '0;
            for (int k = 0; k < 5; k++) begin
               if (k > 0) begin
                  @(posedge clk); #1;
               end
               @(negedge clk);
               check_output("stall_pix_ready", 96'(pr[0]), 96'(0));
               check_output("stall_hold", 96'({wrow[0], wcol[0], wl[0], fw[0]}), snap);
            end
         end else begin
            wr = '1;
         end
      end
   end

   initial begin
      int r0;
      rst = 1'b1;
      pv  = '0;
      pd  = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         check_output("rst_win_valid", 96'(wv[s]), 96'(0));
         check_output("rst_win_last", 96'(wl[s]), 96'(0));
         check_output("rst_win_row", 96'(wrow[s]), 96'(0));
         check_output("rst_win_col", 96'(wcol[s]), 96'(0));
         check_output("rst_win", 96'(fw[s]), 96'(0));
         check_output("rst_pix_ready", 96'(pr[s]), 96'(1));
      end
      @(posedge clk); #1;

      r0 = recv;
      apply_stimulus(0, 4, 4, 3, 3, 0, 1'b0, 16, 0, 1'b1);
      drain(0, 4, r0);

      rmode = 2;
      stalled = 1'b0;
      r0 = recv;
      apply_stimulus(0, 4, 4, 3, 3, 0, 1'b0, 16, 0, 1'b0);
      drain(0, 4, r0);
      check_output("stall_happened", 96'(stalled), 96'(1));
      rmode = 0;

      rmode = 1;
      r0 = recv;
      apply_stimulus(1, 16, 16, 3, 3, 0, 1'b1, 256, 50, 1'b0);
      drain(1, 196, r0);
      rmode = 0;

      r0 = recv;
      apply_stimulus(0, 4, 4, 3, 3, 0, 1'b0, 16, 0, 1'b0);
      apply_stimulus(0, 4, 4, 3, 3, 100, 1'b0, 16, 0, 1'b0);
      drain(0, 8, r0);

      apply_stimulus(0, 4, 4, 3, 3, 0, 1'b0, 7, 0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      check_output("valid_during_reset", 96'(wv[0]), 96'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_output("valid_after_reset", 96'(wv[0]), 96'(0));
      @(posedge clk); #1;
      r0 = recv;
      apply_stimulus(0, 4, 4, 3, 3, 0, 1'b0, 16, 0, 1'b1);
      drain(0, 4, r0);

      r0 = recv;
      apply_stimulus(2, 5, 3, 3, 2, 0, 1'b0, 15, 0, 1'b1);
      drain(2, 4, r0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Streaming sliding-window generator that produces the K_H x K_W unsigned 8-bit pixel windows consumed by the convolution unit. Accepts a raster-order pixel stream (one 8-bit pixel per transfer) and stores K_H-1 previous rows in line buffers. Emits one window per valid output position ("valid" convolution, no padding), with valid/ready backpressure on both sides. Sits between the feature-map read path and the convolution datapath.

## Interface
- IMG_W, default 16: image width in pixels; must be ≥ K_W.
- IMG_H, default 16: image height in rows; must be ≥ K_H.
- K_H, default 3: window height; must be ≥ 2.
- K_W, default 3: window width; must be ≥ 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- pix_valid  input  1  pix_data is valid.
- pix_ready  output  1  block accepts a pixel this cycle.
- pix_data  input  8  unsigned pixel, raster order, row-major.
- win_valid  output  1  window outputs are valid.
- win_ready  input  1  consumer accepts the window this cycle.
- win  output  8 x [K_H-1:0][K_W-1:0]  unsigned window; win[0][0] is top-left, win[K_H-1][K_W-1] is the most recent pixel.
- win_row  output  $clog2(IMG_H)  top-row index of the window in the image.
- win_col  output  $clog2(IMG_W)  left-column index of the window in the image.
- win_last  output  1  high with the final window of a frame.

## Operation
- A pixel is accepted when pix_valid && pix_ready. Window outputs are accepted when win_valid && win_ready.
- pix_ready = !win_valid || win_ready. The block has a single output stage and no internal skid buffer.
- The position counters are col (0..IMG_W-1) and row (0..IMG_H-1). They give the image coordinate of the pixel being accepted.
  - col wraps to 0 after IMG_W-1, and row then increments.
  - row wraps to 0 after IMG_H-1 at col IMG_W-1. The next pixel starts a new frame with no gap and no restart needed.
- There are K_H-1 line buffers, each IMG_W x 8 bits. Line buffer 0 holds the previous row and line buffer K_H-2 holds the oldest row.
- On each accepted pixel at column c:
  - The new window column is {lb[K_H-2][c], ..., lb[0][c], pix_data}, top to bottom.
  - The shift window moves one column left, and the new column enters at index K_W-1.
  - lb[i][c] ← lb[i-1][c] for i ≥ 1, and lb[0][c] ← pix_data.
- Phase state machine, derived from the row counter and registered:
  - FILL while row < K_H-1. No windows are emitted.
  - STREAM while row ≥ K_H-1.
  - STREAM → FILL on acceptance of the last pixel of a frame.
  - FILL → STREAM on acceptance of the last pixel of row K_H-2.
- Emission: an accepted pixel at (row, col) with row ≥ K_H-1 and col ≥ K_W-1 produces a window.
  - win_row = row-K_H+1 and win_col = col-K_W+1.
  - win_last = (row == IMG_H-1 && col == IMG_W-1).
- Windows per frame: (IMG_H-K_H+1)*(IMG_W-K_W+1).
- Window contents are always pixels of the current frame. Stale shift-register columns from the previous row or frame are never emitted, because of the col ≥ K_W-1 condition.
- Line buffer contents are not reset. Stale data is never emitted, because of the row ≥ K_H-1 condition.

## Timing
- Reset values:
  - win_valid=0, win_last=0, win_row=0, win_col=0.
  - All win elements = 0.
  - col=0, row=0, phase=FILL.
  - pix_ready is 1 in the cycle after reset, since it is combinational from win_valid.
- While rst is high:
  - No pixel is accepted.
  - Outputs are held at their reset values.
- Reset mid-frame discards any partial frame and any pending window. The next accepted pixel is image (0,0).
- Latency: win_valid rises on the clock edge that accepts the completing pixel, so the window is visible in the following cycle. This is one cycle of latency.
- Throughput: one pixel per cycle, and one window per cycle in STREAM at col ≥ K_W-1.
- Backpressure: while win_valid && !win_ready:
  - win, win_row, win_col and win_last hold stable.
  - pix_ready=0, and no counter, line buffer or shift-register state changes.
- Simultaneous events: win_ready=1 and an accepted pixel in the same cycle is allowed.
  - The old window retires.
  - The new window, if the pixel produces one, is loaded. Otherwise win_valid falls.
- If pix_valid=0 and win_ready=1, win_valid falls after the handshake.
- The pix_valid=0 gaps do not alter any state.

## Test plan
- IMG_W=4, IMG_H=4, K=3, pixel value = 4r+c, win_ready=1 → exactly 4 windows in order:
  - (0,0): rows {0,1,2},{4,5,6},{8,9,10}.
  - (0,1) and (1,0).
  - (1,1): rows {5,6,7},{9,10,11},{13,14,15}, with win_last=1.
  - The first window_valid appears one cycle after pixel 10 is accepted.
- Same stream with win_ready held low for 5 cycles once the first window is valid → window (0,0) stable for all 5 cycles, pix_ready=0, no pixel lost; the 4 windows are still correct.
- Random pix_valid gaps (50%) and random win_ready (50%) with the default 16x16 frame → 196 windows, each equal to the reference model, win_last only on (13,13).
- Two back-to-back 4x4 frames, second frame values +100 → 8 windows; the second frame's first window is {100,101,102},{104,105,106},{108,109,110}, with no contamination from frame 1.
- rst asserted for 1 cycle after 7 pixels of a frame, then a full 4x4 frame → win_valid=0 during and after reset until pixel 10 of the new frame; exactly 4 correct windows.
- IMG_W=5, IMG_H=3, K_H=3, K_W=2 → 4 windows, all with win_row=0 and win_col 0..3, win_last on col 3.
